// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: deserialises start-bit-framed items received over LANES serial
// wires, optionally checks even parity, and buffers good items in a DEPTH-entry FIFO.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   serial_in    LANES serial wires; lane 0 also carries the start bit
//   item_read    consumer pops the FIFO head (ignored when FIFO empty)
//   valid        FIFO non-empty
//   channel_busy sender must not start a frame while high
//   parallel_out FIFO head item (zero when empty)
//   parity_err   one-cycle pulse when a frame is dropped for bad parity
//   occupancy    number of items held in the FIFO
module serial_rx_fifo #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LANES     = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             serial_in,
  input  logic                         item_read,
  output logic                         valid,
  output logic                         channel_busy,
  output logic [DATA_W-1:0]            parallel_out,
  output logic                         parity_err,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned NBITS   = DATA_W + PARITY_EN;
  localparam int unsigned BEATS   = (NBITS + LANES - 1) / LANES;
  localparam int unsigned FRAME_W = BEATS * LANES;
  localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W   = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         beat_q;
  logic [FRAME_W-1:0]       frame_q;
  logic [FRAME_W-1:0]       frame_d;
  logic [FRAME_W+LANES-1:0] frame_ext;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [OCC_W-1:0]         occ_q;

  logic full;
  logic last_beat;
  logic beat_clr;
  logic beat_inc;
  logic done;
  logic parity_ok;
  logic push;
  logic drop;
  logic pop;
  logic unused_shift_out;

  assign full      = (occ_q == OCC_W'(DEPTH));
  assign last_beat = (beat_q == CNT_W'(BEATS - 1));

  // New beat enters at the top; after BEATS shifts beat 0 sits at bit 0.
  assign frame_ext        = {serial_in, frame_q};
  assign frame_d          = frame_ext[FRAME_W+LANES-1:LANES];
  assign unused_shift_out = ^frame_ext[LANES-1:0];

  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok = (PARITY_EN == 0) || !(^frame_d[NBITS-1:0]);
  assign push      = done && parity_ok;
  assign drop      = done && !parity_ok;
  assign pop       = item_read && valid;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and control decode
  always_comb begin
    state_d  = state_q;
    beat_clr = 1'b0;
    beat_inc = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        // Start bit while full is a sender protocol violation; ignore it.
        if (serial_in[0] && !full) begin
          state_d  = RECV;
          beat_clr = 1'b1;
        end
      end
      RECV: begin
        if (last_beat) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          beat_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat counter, shift register and parity error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q     <= '0;
      frame_q    <= '0;
      parity_err <= 1'b0;
    end else begin
      if (beat_clr) begin
        beat_q <= '0;
      end else if (beat_inc) begin
        beat_q <= beat_q + CNT_W'(1);
      end
      if (state_q == RECV) begin
        frame_q <= frame_d;
      end
      parity_err <= drop;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // FIFO pointers and occupancy; push+pop on one edge leaves occupancy unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // FIFO storage; contents are only observable through the valid-gated head
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= frame_d[DATA_W-1:0];
    end
  end

  assign valid        = (occ_q != '0);
  assign parallel_out = valid ? mem[rd_ptr] : '0;
  assign channel_busy = (state_q == RECV) | full;
  assign occupancy    = occ_q;

endmodule
